// File: rtl/dct_coeff_serializer.sv
`default_nettype none
// dct_coeff_serializer: two-bank ping-pong store that turns a 64-coefficient DCT
// block into a zigzag- or raster-ordered coefficient stream over valid/ready.
module dct_coeff_serializer #(
  parameter int COEFF_W = 16,
  parameter int ZIGZAG  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [64*COEFF_W-1:0] coeff_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [COEFF_W-1:0]   coeff_out,
  output logic [5:0]           out_index,
  output logic                 out_last,
  output logic                 block_dropped,
  output logic                 busy
);

  // Raster address of the k-th coefficient in JPEG zigzag scan.
  localparam logic [5:0] ZZ_TAB [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [COEFF_W-1:0] bank_q [2][64];
  logic [1:0]         full_q, full_d;
  logic               wp_q, wp_d;
  logic               rp_q, rp_d;
  logic [5:0]         idx_q, idx_d;
  logic               drop_q, drop_d;
  logic               cap_en;
  logic               xfer;
  logic               fin_xfer;
  logic [5:0]         raddr;

  assign xfer     = full_q[rp_q] & out_ready;
  assign fin_xfer = xfer & (idx_q == 6'd63);

  always_comb begin
    full_d = full_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    idx_d  = idx_q;
    drop_d = 1'b0;
    cap_en = 1'b0;
    if (xfer) begin
      if (fin_xfer) begin
        idx_d        = 6'd0;
        full_d[rp_q] = 1'b0;
        rp_d         = ~rp_q;
      end else begin
        idx_d = idx_q + 6'd1;
      end
    end
    // A full write bank is still usable when its last word leaves on this edge;
    // the set below overrides the clear above in that case.
    if (in_valid) begin
      if (!full_q[wp_q] || ((wp_q == rp_q) && fin_xfer)) begin
        cap_en       = 1'b1;
        full_d[wp_q] = 1'b1;
        wp_d         = ~wp_q;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 2'b00;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      idx_q  <= 6'd0;
      drop_q <= 1'b0;
    end else begin
      full_q <= full_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      idx_q  <= idx_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_en) begin
      for (int i = 0; i < 64; i++) begin
        bank_q[wp_q][i] <= coeff_in[COEFF_W*i +: COEFF_W];
      end
    end
  end

  assign raddr         = (ZIGZAG != 0) ? ZZ_TAB[idx_q] : idx_q;
  assign out_valid     = full_q[rp_q];
  assign coeff_out     = out_valid ? bank_q[rp_q][raddr] : '0;
  assign out_index     = idx_q;
  assign out_last      = out_valid & (idx_q == 6'd63);
  assign block_dropped = drop_q;
  assign busy          = |full_q;

endmodule
`default_nettype wire

// File: tb/tb_dct_coeff_serializer.sv
`default_nettype none
// Bench for dct_coeff_serializer: zigzag and raster instances checked each cycle
// against a queue-of-blocks reference model.
module tb_dct_coeff_serializer;
  localparam int W = 16;
  typedef logic [64*W-1:0] blk_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  blk_t coeff_in = '0;

  logic         zv, zl, zd, zb, rv, rl, rd, rb;
  logic [W-1:0] zc, rc;
  logic [5:0]   zi, ri;

  dct_coeff_serializer #(.COEFF_W(W), .ZIGZAG(1)) dut_zz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .coeff_in(coeff_in),
    .out_ready(out_ready), .out_valid(zv), .coeff_out(zc), .out_index(zi),
    .out_last(zl), .block_dropped(zd), .busy(zb));

  dct_coeff_serializer #(.COEFF_W(W), .ZIGZAG(0)) dut_rs (
    .clk(clk), .rst(rst), .in_valid(in_valid), .coeff_in(coeff_in),
    .out_ready(out_ready), .out_valid(rv), .coeff_out(rc), .out_index(ri),
    .out_last(rl), .block_dropped(rd), .busy(rb));

  initial forever #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  blk_t mq[$];
  int   midx = 0;
  bit   mdrop = 1'b0;
  int   zz[64];

  // Zigzag order derived by walking anti-diagonals, alternating direction.
  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz[k] = 8*r + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz[k] = 8*r + (s - r); k++; end
      end
    end
  endfunction

  function automatic logic [W-1:0] word(blk_t b, int p);
    return b[W*p +: W];
  endfunction

  function automatic blk_t ramp(int base);
    blk_t b;
    for (int p = 0; p < 64; p++) b[W*p +: W] = W'(p + base);
    return b;
  endfunction

  function automatic blk_t rnd_blk();
    blk_t b;
    for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit           ev = (mq.size() > 0);
    logic [W-1:0] ez = ev ? word(mq[0], zz[midx]) : '0;
    logic [W-1:0] er = ev ? word(mq[0], midx) : '0;
    chk("out_valid", 32'(zv), 32'(ev));
    chk("out_valid_raster", 32'(rv), 32'(ev));
    chk("coeff_zigzag", 32'(zc), 32'(ez));
    chk("coeff_raster", 32'(rc), 32'(er));
    chk("out_index", 32'(zi), 32'(midx));
    chk("out_last", 32'(zl), 32'(ev && midx == 63));
    chk("block_dropped", 32'(zd), 32'(mdrop));
    chk("busy", 32'(zb), 32'(ev));
  endtask

  task automatic model_step(bit iv, bit rdy, blk_t b);
    bit xfer = (mq.size() > 0) && rdy;
    bit fin  = xfer && (midx == 63);
    bit acc  = iv && ((mq.size() < 2) || fin);
    mdrop = iv && !acc;
    if (xfer) begin
      if (fin) begin void'(mq.pop_front()); midx = 0; end
      else midx++;
    end
    if (acc) mq.push_back(b);
  endtask

  // Inputs are applied just after a rising edge, outputs checked on the falling edge.
  task automatic cycle(bit iv, bit rdy, blk_t b);
    in_valid  = iv;
    out_ready = rdy;
    coeff_in  = b;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step(iv, rdy, b);
    #1;
  endtask

  initial begin
    blk_t sblk;
    build_zz();

    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Ramp stream, ready held high.
    cycle(1, 1, ramp(0));
    repeat (70) cycle(0, 1, '0);

    // Signed block: all -1024 except the DC term.
    for (int p = 0; p < 64; p++) sblk[W*p +: W] = 16'hFC00;
    sblk[W-1:0] = 16'd2047;
    cycle(1, 1, sblk);
    repeat (70) cycle(0, 1, '0);

    // Backpressure pattern 1,0,0,1.
    cycle(1, 1, ramp(0));
    for (int i = 0; i < 140; i++) cycle(0, (i % 4 == 0) || (i % 4 == 3), '0);

    // Ping-pong fill, third strobe dropped, then back-to-back drain.
    cycle(1, 0, ramp(0));
    cycle(1, 0, ramp(100));
    cycle(1, 0, ramp(200));
    cycle(0, 0, '0);
    repeat (140) cycle(0, 1, '0);

    // Strobe on the final transfer with both banks full.
    cycle(1, 0, ramp(300));
    cycle(1, 0, ramp(400));
    repeat (63) cycle(0, 1, '0);
    cycle(1, 1, ramp(500));
    cycle(0, 1, '0);
    repeat (140) cycle(0, 1, '0);

    // Asynchronous reset in the middle of a block.
    cycle(1, 1, ramp(7));
    repeat (20) cycle(0, 1, '0);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(zv), 32'd0);
    chk("reset_busy", 32'(zb), 32'd0);
    chk("reset_coeff", 32'(zc), 32'd0);
    chk("reset_index", 32'(zi), 32'd0);
    mq.delete();
    midx  = 0;
    mdrop = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) cycle(0, 1, '0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, rnd_blk());
    repeat (140) cycle(0, 1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
